// File: rtl/gpu_text_writer_pkg.sv
// Shared GPU definitions: controller states, control character codes and bus offsets.
// Both the GPU and the text writer import this package.
package gpu_text_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POLL  = 2'd1,
    WRITE = 2'd2,
    CLEAR = 2'd3
  } gpu_state_t;

  localparam logic [7:0] CHR_NEWLINE   = 8'h0A;
  localparam logic [7:0] CHR_BACKSPACE = 8'h08;
  localparam logic [7:0] CHR_CLEAR     = 8'h0C;
  localparam logic [7:0] CHR_SPACE     = 8'h20;

  localparam logic [7:0]  GPU_DEVICE_SEL = 8'b00000010;
  localparam logic [55:0] GPU_STATUS_OFS = 56'd2;
  localparam logic [55:0] GPU_CHARS_OFS  = 56'd4;

  localparam int CELL_IDX_W = 12;

  function automatic logic is_printable(input logic [7:0] c);
    return !(c == CHR_NEWLINE || c == CHR_BACKSPACE || c == CHR_CLEAR);
  endfunction

endpackage

// File: rtl/gpu_text_writer_cursor.sv
// Cursor position tracker with wrap rules and linear cell index (row*COLUMNS+col).
// Single-cycle update; home has priority over every other request.
module gpu_text_cursor
  import gpu_text_writer_pkg::*;
#(
  parameter int COLUMNS = 80,
  parameter int ROWS    = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  newline,
  input  logic                  back,
  input  logic                  home,
  output logic [4:0]            row,
  output logic [6:0]            col,
  output logic [CELL_IDX_W-1:0] index
);

  localparam logic [6:0] LAST_COL = 7'(COLUMNS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  logic [4:0] row_inc;
  assign row_inc = (row == LAST_ROW) ? 5'd0 : row + 5'd1;

  always_ff @(posedge clk) begin
    if (reset || home) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= row_inc;
      end else begin
        col <= col + 7'd1;
      end
    end else if (newline) begin
      col <= '0;
      row <= row_inc;
    end else if (back) begin
      // Retreating from the origin is the caller's responsibility to suppress.
      if (col != '0) begin
        col <= col - 7'd1;
      end else if (row != '0) begin
        col <= LAST_COL;
        row <= row - 5'd1;
      end
    end
  end

  assign index = CELL_IDX_W'(row) * CELL_IDX_W'(COLUMNS) + CELL_IDX_W'(col);

endmodule

// File: rtl/gpu_text_writer.sv
// Character-stream to GPU text-buffer writer: polls GPU status, then writes one cell.
// Printable: accept N, poll N+1.., write after first idle status; charReady low while busy.
module gpu_text_writer
  import gpu_text_writer_pkg::*;
#(
  parameter logic [7:0]  GPUAddress           = GPU_DEVICE_SEL,
  parameter logic [55:0] GPUStatusAddress     = GPU_STATUS_OFS,
  parameter logic [55:0] GPUCharactersAddress = GPU_CHARS_OFS,
  parameter int          COLUMNS              = 80,
  parameter int          ROWS                 = 30
) (
  input  logic        procClock,
  input  logic        reset,
  input  logic        charValid,
  input  logic [7:0]  charData,
  output logic        charReady,
  output logic        busy,
  output logic [4:0]  cursorRow,
  output logic [6:0]  cursorCol,
  output logic [63:0] address,
  inout  wire  [63:0] data,
  output logic        read,
  output logic        write
);

  localparam logic [CELL_IDX_W-1:0] LAST_CELL = CELL_IDX_W'(ROWS * COLUMNS - 1);

  gpu_state_t state, state_nxt;

  logic [7:0]            code_q;
  logic [CELL_IDX_W-1:0] idx_q;
  logic [CELL_IDX_W-1:0] clr_cnt;
  logic                  is_print_q;
  logic [63:0]           addr_last;
  logic [63:0]           addr_bus;
  logic [63:0]           wdat;
  logic [CELL_IDX_W-1:0] cur_index;

  logic accept, at_origin, clr_last;
  logic cur_advance, cur_newline, cur_back, cur_home;

  assign charReady = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = charValid & charReady;
  assign at_origin = (cursorRow == '0) && (cursorCol == '0);
  assign clr_last  = (clr_cnt == LAST_CELL);

  assign cur_newline = accept && (charData == CHR_NEWLINE);
  assign cur_back    = accept && (charData == CHR_BACKSPACE) && !at_origin;
  assign cur_advance = (state == WRITE) && is_print_q;
  assign cur_home    = (state == CLEAR) && clr_last;

  gpu_text_cursor #(
    .COLUMNS (COLUMNS),
    .ROWS    (ROWS)
  ) u_cursor (
    .clk     (procClock),
    .reset   (reset),
    .advance (cur_advance),
    .newline (cur_newline),
    .back    (cur_back),
    .home    (cur_home),
    .row     (cursorRow),
    .col     (cursorCol),
    .index   (cur_index)
  );

  always_ff @(posedge procClock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (charData == CHR_CLEAR)              state_nxt = CLEAR;
          else if (charData == CHR_NEWLINE)       state_nxt = IDLE;
          else if (charData == CHR_BACKSPACE)     state_nxt = at_origin ? IDLE : POLL;
          else                                    state_nxt = POLL;
        end
      end
      POLL:    state_nxt = data[0] ? POLL : WRITE;
      WRITE:   state_nxt = IDLE;
      CLEAR:   state_nxt = clr_last ? IDLE : CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    read     = 1'b0;
    write    = 1'b0;
    addr_bus = addr_last;
    wdat     = '0;
    case (state)
      POLL: begin
        read     = 1'b1;
        addr_bus = {GPUAddress, GPUStatusAddress};
      end
      WRITE: begin
        write    = 1'b1;
        addr_bus = {GPUAddress, GPUCharactersAddress + 56'(idx_q)};
        wdat     = {56'b0, code_q};
      end
      CLEAR: begin
        write    = 1'b1;
        addr_bus = {GPUAddress, GPUCharactersAddress + 56'(clr_cnt)};
        wdat     = {56'b0, CHR_SPACE};
      end
      default: ;
    endcase
  end

  assign address = addr_bus;
  assign data    = write ? wdat : 64'bz;

  // Backspace targets the cell just behind the cursor, which is index-1 in linear order.
  always_ff @(posedge procClock) begin
    if (reset) begin
      code_q     <= '0;
      idx_q      <= '0;
      clr_cnt    <= '0;
      is_print_q <= 1'b0;
      addr_last  <= '0;
    end else begin
      addr_last <= addr_bus;
      if (accept) begin
        is_print_q <= is_printable(charData);
        code_q     <= is_printable(charData) ? charData : CHR_SPACE;
        idx_q      <= (charData == CHR_BACKSPACE) ? cur_index - CELL_IDX_W'(1) : cur_index;
        clr_cnt    <= '0;
      end else if (state == CLEAR) begin
        clr_cnt <= clr_cnt + CELL_IDX_W'(1);
      end
    end
  end

endmodule
